// File: rtl/ecg_pkg.sv
// Shared constants and types for the ECG sample memory path (write and fetch sides).
package ecg_pkg;

    localparam int unsigned ECG_ADDR_W = 12;
    localparam int unsigned ECG_DATA_W = 12;
    localparam int unsigned ECG_DEPTH  = 4096;
    localparam int unsigned ECG_FILL_W = ECG_ADDR_W + 1;

    // Writer FSM states; the two-phase strobe is SETUP (we low) then STROBE (we high).
    typedef enum logic [2:0] {
        WrIdle   = 3'd0,
        WrArm    = 3'd1,
        WrSetup  = 3'd2,
        WrStrobe = 3'd3,
        WrDone   = 3'd4
    } wr_state_t;

    // A record is in flight in every state between ARM and STROBE inclusive.
    function automatic logic wr_is_busy(input wr_state_t st);
        return (st == WrArm) || (st == WrSetup) || (st == WrStrobe);
    endfunction

endpackage

// File: rtl/ecg_sample_writer_if.sv
// Control, sample-stream and memory-pin bundle of the ECG sample writer.
interface ecg_sample_writer_if
    import ecg_pkg::*;
#(
    parameter int unsigned ADDR_W = ECG_ADDR_W,
    parameter int unsigned DATA_W = ECG_DATA_W
) ();

    // Record control
    logic              start;
    logic              abort;

    // ADC sample stream (valid/ready)
    logic              sample_valid;
    logic [DATA_W-1:0] sample_data;
    logic              sample_ready;

    // Sample memory write pins
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;

    // Status
    logic              busy;
    logic              done;
    logic [ADDR_W:0]   fill_count;

    // Writer side
    modport slave (
        input  start, abort, sample_valid, sample_data,
        output sample_ready, mem_addr, mem_wdata, mem_we, busy, done, fill_count
    );

    // Controller / source / memory side
    modport master (
        output start, abort, sample_valid, sample_data,
        input  sample_ready, mem_addr, mem_wdata, mem_we, busy, done, fill_count
    );

endinterface

// File: rtl/ecg_sample_writer.sv
// ECG sample writer: fills the sample memory sequentially from address 0 with ADC samples
// taken over a valid/ready handshake, using a setup-then-strobe write per sample.
module ecg_sample_writer
    import ecg_pkg::*;
#(
    parameter int unsigned ADDR_W = ECG_ADDR_W,
    parameter int unsigned DATA_W = ECG_DATA_W
) (
    input logic                clk,
    input logic                rst_n,
    ecg_sample_writer_if.slave bus_io
);

    localparam logic [ADDR_W:0] FillMax = (ADDR_W + 1)'(1 << ADDR_W);

    wr_state_t         state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [ADDR_W:0]   fill_q;
    logic              we_q;
    logic              ready_q;
    logic              busy_q;
    logic              done_q;

    logic              handshake;
    logic              last_addr;

    // ready_q is only ever high in ARM, so this is the accept condition of that state.
    assign handshake = ready_q && bus_io.sample_valid;
    assign last_addr = (addr_q == {ADDR_W{1'b1}});

    // Writer FSM; every output is a flop so nothing combinational reaches the pins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= WrIdle;
            addr_q  <= '0;
            wdata_q <= '0;
            fill_q  <= '0;
            we_q    <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            unique case (state_q)
                // Abort has no effect here; done survives until the next start.
                WrIdle, WrDone: begin
                    if (bus_io.start) begin
                        state_q <= WrArm;
                        addr_q  <= '0;
                        fill_q  <= '0;
                        done_q  <= 1'b0;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end

                WrArm: begin
                    if (bus_io.abort) begin
                        state_q <= WrIdle;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b0;
                    end else if (handshake) begin
                        wdata_q <= bus_io.sample_data;
                        state_q <= WrSetup;
                        ready_q <= 1'b0;
                    end
                end

                // Address and data settle for a cycle before the strobe.
                WrSetup: begin
                    if (bus_io.abort) begin
                        state_q <= WrIdle;
                        busy_q  <= 1'b0;
                    end else begin
                        state_q <= WrStrobe;
                        we_q    <= 1'b1;
                    end
                end

                // The write lands this cycle even when aborting, so it is always counted.
                WrStrobe: begin
                    we_q   <= 1'b0;
                    addr_q <= addr_q + 1'b1;
                    fill_q <= fill_q + 1'b1;
                    if (bus_io.abort) begin
                        state_q <= WrIdle;
                        busy_q  <= 1'b0;
                    end else if (last_addr) begin
                        // addr_q wraps to 0; fill_q tops out at the depth.
                        state_q <= WrDone;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                    end else begin
                        state_q <= WrArm;
                        ready_q <= 1'b1;
                    end
                end

                default: begin
                    state_q <= WrIdle;
                    we_q    <= 1'b0;
                    ready_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus_io.sample_ready = ready_q;
    assign bus_io.mem_addr     = addr_q;
    assign bus_io.mem_wdata    = wdata_q;
    assign bus_io.mem_we       = we_q;
    assign bus_io.busy         = busy_q;
    assign bus_io.done         = done_q;
    assign bus_io.fill_count   = fill_q;

    // Structural invariants of the strobe protocol and status flags.
    a_we_not_ready: assert property (@(posedge clk) disable iff (!rst_n)
        we_q |-> !ready_q);
    a_we_in_strobe: assert property (@(posedge clk) disable iff (!rst_n)
        we_q |-> (state_q == WrStrobe));
    a_busy_state: assert property (@(posedge clk) disable iff (!rst_n)
        busy_q == wr_is_busy(state_q));
    a_done_idle: assert property (@(posedge clk) disable iff (!rst_n)
        done_q |-> !busy_q);
    a_fill_bound: assert property (@(posedge clk) disable iff (!rst_n)
        fill_q <= FillMax);

endmodule

// File: tb/tb_ecg_sample_writer.sv
// Self-checking bench for ecg_sample_writer: a per-cycle timing model of the record rules
// plus literal expectations at the interesting points of each directed scenario.
module tb_ecg_sample_writer;
    import ecg_pkg::*;

    localparam int unsigned AW = ECG_ADDR_W;
    localparam int unsigned DW = ECG_DATA_W;
    localparam logic [AW:0] LastCnt = (AW + 1)'(ECG_DEPTH - 1);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ecg_sample_writer_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
    ecg_sample_writer #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_io (bus)
    );

    // Model: a record is "active"; within it, phase counts clocks since a sample was taken
    // (0 = waiting for a sample, 1 = one clock after, 2 = strobe clock).
    logic          m_active;
    logic [1:0]    m_phase;
    logic [AW:0]   m_count;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic          m_done;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active <= 1'b0;
            m_phase  <= 2'd0;
            m_count  <= '0;
            m_addr   <= '0;
            m_wdata  <= '0;
            m_done   <= 1'b0;
        end else if (!m_active) begin
            if (bus.start) begin
                m_active <= 1'b1;
                m_phase  <= 2'd0;
                m_count  <= '0;
                m_addr   <= '0;
                m_done   <= 1'b0;
            end
        end else if (m_phase == 2'd0) begin
            if (bus.abort) m_active <= 1'b0;
            else if (bus.sample_valid) begin
                m_wdata <= bus.sample_data;
                m_phase <= 2'd1;
            end
        end else if (m_phase == 2'd1) begin
            if (bus.abort) m_active <= 1'b0;
            else m_phase <= 2'd2;
        end else begin
            m_count <= m_count + 1'b1;
            m_addr  <= m_addr + 1'b1;
            m_phase <= 2'd0;
            if (bus.abort) m_active <= 1'b0;
            else if (m_count == LastCnt) begin
                m_active <= 1'b0;
                m_done   <= 1'b1;
            end
        end
    end

    // Handshake seen by the source (stimulus bookkeeping only).
    logic acc_q = 1'b0;
    always @(posedge clk) acc_q <= bus.sample_valid && bus.sample_ready;

    int n_chk  = 0;
    int n_fail = 0;
    int n_wr   = 0;
    logic src_en = 1'b0;
    int src_idx = 0;
    int src_gap = 0;
    int gap_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic compare_all();
        chk("sample_ready", 32'(bus.sample_ready), 32'(m_active && m_phase == 2'd0));
        chk("mem_we",       32'(bus.mem_we),       32'(m_active && m_phase == 2'd2));
        chk("busy",         32'(bus.busy),         32'(m_active));
        chk("done",         32'(bus.done),         32'(m_done));
        chk("fill_count",   32'(bus.fill_count),   32'(m_count));
        chk("mem_addr",     32'(bus.mem_addr),     32'(m_addr));
        chk("mem_wdata",    32'(bus.mem_wdata),    32'(m_wdata));
    endtask

    // One clock: check outputs at the falling edge, then drive inputs for the next rise.
    task automatic cycle(input logic s, input logic a);
        @(negedge clk);
        compare_all();
        if (bus.mem_we) n_wr++;
        bus.start = s;
        bus.abort = a;
        if (!src_en) begin
            bus.sample_valid = 1'b0;
        end else begin
            if (acc_q) begin
                src_idx++;
                bus.sample_valid = 1'b0;
                gap_cnt = src_gap;
            end
            if (!bus.sample_valid) begin
                if (gap_cnt == 0) begin
                    bus.sample_valid = 1'b1;
                    bus.sample_data  = DW'(src_idx + 1);
                end else begin
                    gap_cnt--;
                end
            end
        end
    endtask

    task automatic start_rec(input int gap);
        src_en  = 1'b1;
        src_idx = 0;
        src_gap = gap;
        gap_cnt = 0;
        n_wr    = 0;
        bus.sample_valid = 1'b0;
        cycle(1'b1, 1'b0);
    endtask

    initial begin
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.sample_valid = 1'b0;
        bus.sample_data = '0;

        // Reset values
        cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b0);
        rst_n = 1'b1;
        cycle(1'b0, 1'b0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_fill", 32'(bus.fill_count), 32'd0);
        chk("rst_ready", 32'(bus.sample_ready), 32'd0);

        // Full record at maximum rate, data = address + 1
        start_rec(0);
        for (int n = 0; n < 20 && !bus.mem_we; n++) cycle(1'b0, 1'b0);
        chk("t1_first_we", 32'(bus.mem_we), 32'd1);
        chk("t1_first_addr", 32'(bus.mem_addr), 32'd0);
        chk("t1_first_data", 32'(bus.mem_wdata), 32'd1);
        for (int n = 0; n < 13000 && !bus.done; n++) cycle(1'b0, 1'b0);
        chk("t1_done", 32'(bus.done), 32'd1);
        chk("t1_fill", 32'(bus.fill_count), 32'd4096);
        chk("t1_addr", 32'(bus.mem_addr), 32'd0);
        chk("t1_last_data", 32'(bus.mem_wdata), 32'd0);
        chk("t1_writes", 32'(n_wr), 32'd4096);
        chk("t1_busy", 32'(bus.busy), 32'd0);

        // Abort in DONE keeps done
        cycle(1'b0, 1'b1);
        cycle(1'b0, 1'b0);
        chk("done_abort_keeps", 32'(bus.done), 32'd1);

        // Sparse source: one offer per 7 clocks; start from DONE
        start_rec(6);
        cycle(1'b0, 1'b0);
        chk("t2_done_clr", 32'(bus.done), 32'd0);
        chk("t2_fill_clr", 32'(bus.fill_count), 32'd0);
        for (int n = 0; n < 400 && bus.fill_count != 20; n++) cycle(1'b0, 1'b0);
        chk("t2_fill", 32'(bus.fill_count), 32'd20);
        chk("t2_writes", 32'(n_wr), 32'd20);
        src_en = 1'b0;
        for (int n = 0; n < 4; n++) cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b1);
        cycle(1'b0, 1'b0);
        chk("t2_abort_busy", 32'(bus.busy), 32'd0);

        // Abort in SETUP of sample 10
        start_rec(0);
        cycle(1'b0, 1'b0);
        for (int n = 0; n < 100 && bus.fill_count != 10; n++) cycle(1'b0, 1'b0);
        src_en = 1'b0;
        cycle(1'b0, 1'b1);
        cycle(1'b0, 1'b0);
        chk("t3_fill", 32'(bus.fill_count), 32'd10);
        chk("t3_writes", 32'(n_wr), 32'd10);
        chk("t3_busy", 32'(bus.busy), 32'd0);
        chk("t3_done", 32'(bus.done), 32'd0);

        // Abort coinciding with STROBE of sample 10
        start_rec(0);
        cycle(1'b0, 1'b0);
        for (int n = 0; n < 100 && bus.fill_count != 10; n++) cycle(1'b0, 1'b0);
        src_en = 1'b0;
        cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b1);
        cycle(1'b0, 1'b0);
        chk("t4_fill", 32'(bus.fill_count), 32'd11);
        chk("t4_writes", 32'(n_wr), 32'd11);
        chk("t4_busy", 32'(bus.busy), 32'd0);

        // Mid-record start ignored; start+abort while busy aborts
        start_rec(0);
        for (int n = 0; n < 8; n++) cycle(1'b0, 1'b0);
        cycle(1'b1, 1'b0);
        for (int n = 0; n < 4; n++) cycle(1'b0, 1'b0);
        chk("t5_still_busy", 32'(bus.busy), 32'd1);
        chk("t5_fill_kept", 32'(bus.fill_count), 32'd4);
        cycle(1'b1, 1'b1);
        cycle(1'b0, 1'b0);
        chk("t5_abort_busy", 32'(bus.busy), 32'd0);
        src_en = 1'b0;
        // start+abort while idle: start is honoured
        cycle(1'b1, 1'b1);
        cycle(1'b0, 1'b0);
        chk("t5_idle_start", 32'(bus.busy), 32'd1);
        chk("t5_idle_ready", 32'(bus.sample_ready), 32'd1);
        cycle(1'b0, 1'b1);
        cycle(1'b0, 1'b0);

        // Reset dropped between edges during STROBE
        start_rec(0);
        for (int n = 0; n < 20 && !bus.mem_we; n++) cycle(1'b0, 1'b0);
        chk("t6_we_before", 32'(bus.mem_we), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("t6_we_async", 32'(bus.mem_we), 32'd0);
        chk("t6_busy", 32'(bus.busy), 32'd0);
        chk("t6_fill", 32'(bus.fill_count), 32'd0);
        chk("t6_addr", 32'(bus.mem_addr), 32'd0);
        chk("t6_wdata", 32'(bus.mem_wdata), 32'd0);
        chk("t6_done", 32'(bus.done), 32'd0);
        src_en = 1'b0;
        cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b0);
        rst_n = 1'b1;
        cycle(1'b0, 1'b0);
        start_rec(0);
        for (int n = 0; n < 20 && !bus.mem_we; n++) cycle(1'b0, 1'b0);
        chk("t6_restart_we", 32'(bus.mem_we), 32'd1);
        chk("t6_restart_addr", 32'(bus.mem_addr), 32'd0);
        chk("t6_restart_data", 32'(bus.mem_wdata), 32'd1);
        for (int n = 0; n < 6; n++) cycle(1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ecg_sample_writer.md
# ecg_sample_writer

Write-side counterpart of the ECG sample fetch path: accepts a stream of ADC samples over a valid/ready handshake and writes them into the 4096-entry sample memory at sequential addresses from 0. It drives the memory's address, data and write-strobe pins, using the same two-phase strobe the read side uses. It reports the fill level and raises `done` once the whole memory holds a fresh record, so the fetch unit can then replay it.

## Interface
- `ADDR_W`, 12, memory address width; depth = 2**ADDR_W
- `DATA_W`, 12, sample width (ADC resolution)

Ports:
- `clk`  in  1  system clock, all logic on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  one-cycle pulse; begins a record from address 0
- `abort`  in  1  one-cycle pulse; abandons the current record
- `sample_valid`  in  1  source has a sample on `sample_data`
- `sample_data`  in  DATA_W  ADC sample
- `sample_ready`  out  1  writer accepts a sample this cycle
- `mem_addr`  out  ADDR_W  write address to sample memory
- `mem_wdata`  out  DATA_W  write data to sample memory
- `mem_we`  out  1  write strobe, one cycle per sample
- `busy`  out  1  record in progress
- `done`  out  1  full record written; held until next `start`
- `fill_count`  out  ADDR_W+1  samples written in current/last record, 0..2**ADDR_W

## Operation
- FSM states: IDLE, ARM, SETUP, STROBE, DONE.
- IDLE: `busy`=0, `sample_ready`=0. `start` -> ARM, clear address to 0, `fill_count` to 0, and `done` to 0.
- ARM: `sample_ready`=1. On `sample_valid`&&`sample_ready`, latch `sample_data` into `mem_wdata` and go to SETUP. Otherwise stay in ARM.
- SETUP: address and data are stable, `mem_we`=0 (memory setup phase).
- STROBE: `mem_we`=1 for exactly this cycle. `fill_count` increments on exit.
  - If `mem_addr` == 2**ADDR_W-1: go to DONE, and `mem_addr` wraps to 0.
  - Otherwise increment `mem_addr` and return to ARM.
- DONE: `done`=1, `busy`=0. `start` -> ARM, behaving exactly as `start` from IDLE.
- `busy`=1 in ARM, SETUP and STROBE.
- `start` while `busy` is ignored.
- `abort` in ARM or SETUP -> IDLE, with no write performed.
- `abort` in STROBE: the write completes this cycle, `fill_count` still increments, and the next state is IDLE.
- `abort` in IDLE or DONE: no effect; `done` is preserved.
- `abort` and `start` in the same cycle: `abort` wins while busy. Otherwise `start` is processed normally.
- `sample_ready` is low in SETUP and STROBE. The source must hold `sample_valid` and `sample_data` until accepted; no sample is ever dropped or duplicated.
- Maximum throughput is one sample per 3 clocks.
- `fill_count` saturates naturally at 2**ADDR_W, which is why it is ADDR_W+1 bits wide.

## Timing
- Reset (asynchronous assert, synchronous release):
  - state=IDLE
  - `mem_addr`=0, `mem_wdata`=0
  - `mem_we`=0, `sample_ready`=0, `busy`=0, `done`=0
  - `fill_count`=0
- `start` at edge N: `sample_ready`=1 from N+1.
- Handshake at edge N: SETUP at N+1, `mem_we`=1 during N+2, `sample_ready`=1 again at N+3.
- Reset asserted mid-record: all outputs return to reset values immediately, and `mem_we` drops asynchronously. A partially filled memory is not flagged as `done`.
- All outputs are registered; there is no combinational path from any input to any output.

## Structure
- Shared package `ecg_pkg`:
  - state enum `wr_state_t`
  - `ECG_ADDR_W`=12, `ECG_DATA_W`=12
  - `ECG_DEPTH`=4096
- Both this block and the fetch unit take these constants from `ecg_pkg`.
- Single module, no sub-modules. The address/fill counter pair is small enough to stay inline.

## Test plan
- Reset, then `start`, with `sample_valid` held high and data = address+1 -> 4096 strobes at 3-clock spacing, addr 0..0xFFF carrying data 1..0x1000 (truncated to 12 bits); `done`=1, `fill_count`=4096, `mem_addr`=0.
- Source asserts `sample_valid` only every 7 clocks -> exactly one `mem_we` per accepted sample, data matching, no duplicates; `fill_count` tracks the number of accepted samples.
- `abort` while in SETUP at sample 10 -> no write for sample 10, IDLE, `fill_count`=10, `done`=0.
- `abort` coinciding with STROBE of sample 10 -> sample 10 written, `fill_count`=11, IDLE.
- `start` pulsed mid-record and `start`+`abort` issued together -> the mid-record `start` is ignored; the combined pulse aborts.
- `rst_n` dropped between edges during STROBE -> `mem_we` falls immediately and all outputs are 0. A subsequent `start` records from address 0.
